// File: rtl/hyper_phy_sched.sv
// Serialises requester transactions onto a single HyperBus PHY command port.
// Round-robin grant, one transaction in flight, programmable CS-high gap, idle-only PHY-mode switch.
module hyper_phy_sched #(
    parameter int NumReq       = 2,
    parameter int NumChips     = 2,
    parameter int NumPhys      = 2,
    parameter int AddrWidth    = 32,
    parameter int LenWidth     = 8,
    parameter int ChipSizeLog2 = 23,
    localparam int IdW         = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int CsW         = (NumChips > 1) ? $clog2(NumChips) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cfg_phys_in_use_i,
    input  logic [3:0]                    cfg_t_csh_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*LenWidth-1:0]    req_len_i,
    input  logic [NumReq-1:0]             req_write_i,
    output logic                          phy_trans_valid_o,
    input  logic                          phy_trans_ready_i,
    output logic [AddrWidth-1:0]          phy_trans_addr_o,
    output logic [LenWidth-1:0]           phy_trans_len_o,
    output logic                          phy_trans_write_o,
    output logic [NumChips-1:0]           phy_trans_cs_o,
    output logic [IdW-1:0]                phy_trans_id_o,
    input  logic                          phy_done_i,
    output logic                          phys_in_use_o,
    output logic                          busy_o,
    output logic [1:0]                    dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IdW-1:0]        rr_ptr_q;
    logic [3:0]            gap_cnt_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [LenWidth-1:0]   len_q;
    logic                  write_q;
    logic [NumChips-1:0]   cs_q;
    logic [IdW-1:0]        id_q;
    logic                  phys_q;

    logic                  grant_found;
    logic [IdW-1:0]        grant_idx;
    logic [IdW-1:0]        rr_next;
    logic [AddrWidth-1:0]  sel_addr;
    logic [CsW-1:0]        chip_idx;
    logic [NumChips-1:0]   cs_next;

    // First valid requester at or after the pointer; descending scan so the nearest offset wins.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            cand = (int'(rr_ptr_q) + i) % NumReq;
            if (req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IdW'(cand);
            end
        end
    end

    assign rr_next  = (int'(grant_idx) == NumReq - 1) ? '0 : grant_idx + IdW'(1);
    assign sel_addr = req_addr_i[int'(grant_idx)*AddrWidth +: AddrWidth];
    assign chip_idx = sel_addr[ChipSizeLog2 +: CsW];

    always_comb begin
        cs_next = '0;
        for (int c = 0; c < NumChips; c++) begin
            cs_next[c] = (NumChips == 1) ? 1'b1 : (int'(chip_idx) == c);
        end
    end

    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // req_ready_o is only raised in IDLE for the winner, phy_trans_valid_o holds with
    // stable payload until phy_trans_ready_i is seen.
    always_comb begin
        req_ready_o = '0;
        for (int r = 0; r < NumReq; r++) begin
            req_ready_o[r] = (state_q == S_IDLE) && grant_found && (int'(grant_idx) == r);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_found) state_d = S_ISSUE;
            S_ISSUE: if (phy_trans_ready_i) state_d = S_BUSY;
            S_BUSY:  if (phy_done_i) state_d = (cfg_t_csh_i == 4'd0) ? S_IDLE : S_GAP;
            S_GAP:   if (gap_cnt_q <= 4'd1) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            gap_cnt_q <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            write_q   <= 1'b0;
            cs_q      <= '0;
            id_q      <= '0;
            phys_q    <= (NumPhys == 2);
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    // Mode only changes here so a switch can never land inside a burst.
                    phys_q <= (NumPhys == 2) && cfg_phys_in_use_i;
                    if (grant_found) begin
                        addr_q   <= sel_addr;
                        len_q    <= req_len_i[int'(grant_idx)*LenWidth +: LenWidth];
                        write_q  <= req_write_i[grant_idx];
                        cs_q     <= cs_next;
                        id_q     <= grant_idx;
                        rr_ptr_q <= rr_next;
                    end
                end
                S_BUSY: if (phy_done_i) gap_cnt_q <= cfg_t_csh_i;
                S_GAP:  gap_cnt_q <= gap_cnt_q - 4'd1;
                default: ;
            endcase
        end
    end

    assign phy_trans_valid_o = (state_q == S_ISSUE);
    assign phy_trans_addr_o  = addr_q;
    assign phy_trans_len_o   = len_q;
    assign phy_trans_write_o = write_q;
    assign phy_trans_cs_o    = cs_q;
    assign phy_trans_id_o    = id_q;
    assign phys_in_use_o     = phys_q;
    assign busy_o            = (state_q != S_IDLE);
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_hyper_phy_sched.sv
// Directed bench for hyper_phy_sched: grant order, latency, CS gap, stall hold, mode switch, reset.
module tb_hyper_phy_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_phys;
    logic [3:0]  cfg_t_csh;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_addr;
    logic [15:0] req_len;
    logic [1:0]  req_write;
    logic        trans_valid;
    logic        trans_ready;
    logic [31:0] trans_addr;
    logic [7:0]  trans_len;
    logic        trans_write;
    logic [1:0]  trans_cs;
    logic [0:0]  trans_id;
    logic        done;
    logic        phys_in_use;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_BUSY = 2'd2, ST_GAP = 2'd3;

    hyper_phy_sched dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .cfg_phys_in_use_i (cfg_phys),
        .cfg_t_csh_i       (cfg_t_csh),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_addr_i        (req_addr),
        .req_len_i         (req_len),
        .req_write_i       (req_write),
        .phy_trans_valid_o (trans_valid),
        .phy_trans_ready_i (trans_ready),
        .phy_trans_addr_o  (trans_addr),
        .phy_trans_len_o   (trans_len),
        .phy_trans_write_o (trans_write),
        .phy_trans_cs_o    (trans_cs),
        .phy_trans_id_o    (trans_id),
        .phy_done_i        (done),
        .phys_in_use_o     (phys_in_use),
        .busy_o            (busy),
        .dbg_state_o       (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'(2'b00));
        chk({tag, "_valid"}, 64'(trans_valid), 64'(1'b0));
        chk({tag, "_addr"},  64'(trans_addr), 64'(32'h0));
        chk({tag, "_len"},   64'(trans_len), 64'(8'h0));
        chk({tag, "_write"}, 64'(trans_write), 64'(1'b0));
        chk({tag, "_cs"},    64'(trans_cs), 64'(2'b00));
        chk({tag, "_id"},    64'(trans_id), 64'(1'b0));
        chk({tag, "_busy"},  64'(busy), 64'(1'b0));
        chk({tag, "_phys"},  64'(phys_in_use), 64'(1'b1));
    endtask

    // Driver: from ISSUE, hand over the command, then signal done; leaves bench `gap` cycles after done.
    task automatic finish_txn(input int gap);
        trans_ready = 1'b1;
        tick();
        trans_ready = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        repeat (gap) tick();
    endtask

    initial begin
        rst         = 1'b1;
        cfg_phys    = 1'b1;
        cfg_t_csh   = 4'd0;
        req_valid   = 2'b00;
        req_addr    = '0;
        req_len     = '0;
        req_write   = 2'b00;
        trans_ready = 1'b0;
        done        = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Single write from req0 into chip 1, t_csh = 2.
        cfg_t_csh = 4'd2;
        req_valid = 2'b01;
        req_addr  = {32'h0, 32'h0080_0000};
        req_len   = {8'd0, 8'd15};
        req_write = 2'b01;
        #1;
        chk("t1_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = 2'b00;
        #1;
        chk("t1_valid_n1", 64'(trans_valid), 64'(1'b1));
        chk("t1_addr", 64'(trans_addr), 64'(32'h0080_0000));
        chk("t1_len", 64'(trans_len), 64'(8'd15));
        chk("t1_write", 64'(trans_write), 64'(1'b1));
        chk("t1_cs", 64'(trans_cs), 64'(2'b10));
        chk("t1_id", 64'(trans_id), 64'(1'b0));
        chk("t1_busy", 64'(busy), 64'(1'b1));
        trans_ready = 1'b1;
        tick();
        trans_ready = 1'b0;
        chk("t1_valid_busy", 64'(trans_valid), 64'(1'b0));
        // req1 read arrives while busy; must wait out the gap.
        req_valid = 2'b10;
        req_addr  = {32'h0000_0100, 32'h0};
        req_len   = {8'd3, 8'd0};
        req_write = 2'b00;
        #1;
        chk("t1_busy_noready", 64'(req_ready), 64'(2'b00));
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t1_gap1_noready", 64'(req_ready), 64'(2'b00));
        chk("t1_gap1_state", 64'(dbg_state), 64'(ST_GAP));
        tick();
        chk("t1_gap2_noready", 64'(req_ready), 64'(2'b00));
        tick();
        chk("t1_regrant_d3", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = 2'b00;
        chk("t1b_id", 64'(trans_id), 64'(1'b1));
        chk("t1b_cs", 64'(trans_cs), 64'(2'b01));
        chk("t1b_len", 64'(trans_len), 64'(8'd3));
        chk("t1b_write", 64'(trans_write), 64'(1'b0));
        cfg_t_csh = 4'd0;
        finish_txn(0);
        chk("t1b_idle", 64'(dbg_state), 64'(ST_IDLE));

        // Both requesters held valid: grants alternate 0,1,0,1 and regrant the cycle after done.
        req_valid = 2'b11;
        req_addr  = {32'h00C0_0000, 32'h0000_1000};
        req_len   = {8'd7, 8'd1};
        req_write = 2'b10;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", 64'(req_ready), (k % 2 == 1) ? 64'(2'b10) : 64'(2'b01));
            tick();
            chk("rr_id", 64'(trans_id), 64'(k % 2));
            chk("rr_cs", 64'(trans_cs), (k % 2 == 1) ? 64'(2'b10) : 64'(2'b01));
            finish_txn(0);
        end
        req_valid = 2'b00;

        // PHY stalls 5 cycles in ISSUE.
        req_valid = 2'b01;
        req_addr  = {32'h0, 32'h0080_0040};
        req_len   = {8'd0, 8'd31};
        tick();
        req_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_valid", 64'(trans_valid), 64'(1'b1));
            chk("stall_addr", 64'(trans_addr), 64'(32'h0080_0040));
            chk("stall_len", 64'(trans_len), 64'(8'd31));
            chk("stall_cs", 64'(trans_cs), 64'(2'b10));
            chk("stall_id", 64'(trans_id), 64'(1'b0));
            chk("stall_ready", 64'(req_ready), 64'(2'b00));
            tick();
        end
        req_valid = 2'b00;
        finish_txn(0);

        // PHY-mode switch requested mid-transaction only lands once idle.
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        trans_ready = 1'b1;
        tick();
        trans_ready = 1'b0;
        cfg_phys = 1'b0;
        tick();
        chk("mode_busy_hold", 64'(phys_in_use), 64'(1'b1));
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("mode_idle_applied", 64'(phys_in_use), 64'(1'b0));
        cfg_phys = 1'b1;
        tick();
        chk("mode_idle_back", 64'(phys_in_use), 64'(1'b1));

        // Reset while BUSY drops the transaction.
        req_valid = 2'b01;
        req_addr  = {32'h0, 32'h0080_0000};
        tick();
        req_valid = 2'b00;
        trans_ready = 1'b1;
        tick();
        trans_ready = 1'b0;
        chk("rst_pre_busy", 64'(dbg_state), 64'(ST_BUSY));
        cfg_phys = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_busy");
        cfg_phys = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 2'b10;
        #1;
        chk("rst_regrant", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = 2'b00;
        chk("rst_regrant_id", 64'(trans_id), 64'(1'b1));
        finish_txn(0);

        // Spurious done in IDLE and in GAP.
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("spur_idle_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("spur_idle_busy", 64'(busy), 64'(1'b0));
        cfg_t_csh = 4'd3;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        finish_txn(0);
        cfg_t_csh = 4'd0;
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("spur_gap_state", 64'(dbg_state), 64'(ST_GAP));
        tick();
        chk("spur_gap_state2", 64'(dbg_state), 64'(ST_GAP));
        tick();
        chk("spur_gap_idle", 64'(dbg_state), 64'(ST_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
